// File: rtl/dmem_if.sv
// Load/store handshake between the M stage (master) and the data-memory responder (slave).
interface dmem_if;
    logic        memreq;
    logic        memwrite;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        done;
    logic        err;

    modport master (
        output memreq, memwrite, addr, be, wdata,
        input  rdata, stall, done, err
    );

    modport slave (
        input  memreq, memwrite, addr, be, wdata,
        output rdata, stall, done, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: wait-stated, byte-masked word store / registered word load.
// Optional misalignment trap enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder #(
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic   clk,
    input  logic   rst,
    dmem_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   mem [2**AW];
    logic [AW-1:0] idx;
    logic          access;
    logic          misaligned;
    logic          unused_addr_bits;

    assign idx              = bus.addr[AW+1:2];
    assign unused_addr_bits = ^{bus.addr[31:AW+2], bus.addr[1:0]};
    // Fields are sampled here, at the access edge, not at acceptance.
    assign access           = (state_q == WAIT) && (cnt_q == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    logic err_q, err_d;

    function automatic logic is_misaligned(input logic [3:0] be, input logic [1:0] a);
        return ((be == 4'hF) && (a != 2'b00)) ||
               (((be == 4'b0011) || (be == 4'b1100)) && a[0]);
    endfunction

    assign misaligned = is_misaligned(bus.be, bus.addr[1:0]);
    assign err_d      = access ? misaligned : err_q;
    assign bus.err    = (state_q == DONE) && err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end
`else
    assign misaligned = 1'b0;
    assign bus.err    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.memreq) begin
                state_d = WAIT;
                cnt_d   = 4'(WAIT_CYCLES);
            end
            WAIT: if (cnt_q == 4'd0) state_d = DONE;
                  else               cnt_d   = cnt_q - 4'd1;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (access && !bus.memwrite)
            rdata_d = misaligned ? 32'd0 : mem[idx];
    end

    // Array is not reset; a store aborted by reset never reaches this edge.
    always_ff @(posedge clk) begin
        if (access && bus.memwrite && !misaligned) begin
            for (int i = 0; i < 4; i++)
                if (bus.be[i]) mem[idx][8*i +: 8] <= bus.wdata[8*i +: 8];
        end
    end

    // Output logic
    always_comb begin
        bus.stall = rst && bus.memreq && (state_q != DONE);
        bus.done  = (state_q == DONE);
        bus.rdata = rdata_q;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined MIPS core: the memory-side end of the M-stage load/store interface. It accepts a word-addressed request from the memory stage, holds the pipeline with a stall while a configurable number of wait states elapse, then performs the byte-masked write or registered read. It is the slave counterpart of the core's `aluoutM`/`writedataM`/`readdataM` path and sits between the datapath and the on-chip data RAM.

## Interface
Parameters:
- `AW`, 8, word-address width; the array holds 2^AW 32-bit words.
- `WAIT_CYCLES`, 2, extra wait states per access (0..15).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `memreq`  in  1  request valid from the M stage; held stable with `addr`/`wdata`/`be`/`memwrite` while `stall` is high.
- `memwrite`  in  1  1 = store, 0 = load.
- `addr`  in  32  byte address; word index = `addr[AW+1:2]`; higher bits ignored, so addresses wrap modulo 2^AW words.
- `be`  in  4  byte enables; on stores selects the bytes written; on loads gives access size for the alignment check only.
- `wdata`  in  32  store data, already lane-aligned.
- `rdata`  out  32  load data, valid in the `done` cycle and held until the next load completes.
- `stall`  out  1  freezes the pipeline while an accepted request is outstanding.
- `done`  out  1  one-cycle pulse when an access completes.
- `err`  out  1  one-cycle pulse with `done` on a misaligned access (only with `DMEM_ALIGN_CHECK_EN`).

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE: when `memreq`=1, go to WAIT and load `cnt` with `WAIT_CYCLES`. Otherwise stay in IDLE.
- WAIT: if `cnt`=0, perform the access on this edge and go to DONE. Otherwise decrement `cnt`.
- Access, store: for each i, if `be[i]` then `mem[idx][8i+7:8i]` <= `wdata[8i+7:8i]`. If `be`=0, memory is unchanged but the handshake still completes.
- Access, load: `rdata` <= `mem[idx]` as a full word. Lane selection and sign extension are the core's job.
- DONE: `done`=1 and `stall`=0. Always go to IDLE next.
- `stall` is combinational: `memreq` & (state != DONE), forced to 0 while `rst` is low.
- Back-to-back: a request present in the cycle after DONE is accepted immediately from IDLE.
- A `memreq` deassert during WAIT is an initiator protocol violation. The access still completes as latched.
- Request fields are sampled at the access edge, not at acceptance.
- Memory contents are not initialised by reset.

## Timing
- Reset values: state=IDLE, `cnt`=0, `rdata`=0, `done`=0, `err`=0, `stall`=0.
- Reset mid-operation clears the FSM at once. A store not yet at its access edge is never written; one already written stays written.
- Latency: request first seen high before edge N. The access happens at edge N+WAIT_CYCLES+1, and `done` is high in the cycle that follows.
- `stall` is high for exactly WAIT_CYCLES+2 cycles per access: the request cycle plus the WAIT cycles. With WAIT_CYCLES=0 it is high for 2 cycles.
- The pipeline advances at the edge ending the DONE cycle. `rdata` is registered, so the W-stage flop captures it at that edge.

## Configuration
- `DMEM_ALIGN_CHECK_EN` defined:
  - misaligned = (`be`=4'hF & `addr[1:0]`!=0) | ((`be`=4'b0011 | `be`=4'b1100) & `addr[0]`).
  - On a misaligned access the write is suppressed, `rdata` <= 0, and `err` pulses with `done`.
- Not defined: `addr[1:0]` is ignored, `err` is tied to 0, and all accesses proceed.

## Test plan
- Reset with `memreq`=1 held -> `stall`=0, `rdata`=0, `done`=0. After release, the request is accepted with `stall`=1 on the next cycle.
- WAIT_CYCLES=2, store 0xDEADBEEF to 0x10 with `be`=F, then load 0x10 -> each access has `stall` high for 4 cycles and `done` on the 5th; load `rdata`=0xDEADBEEF.
- Store 0x000000AA to 0x10 with `be`=4'b0001 over 0xDEADBEEF, then load -> `rdata`=0xDEADBEAA. A store with `be`=0 leaves the word unchanged.
- AW=8: store 0x12345678 to 0x400, then load 0x000 -> `rdata`=0x12345678 (wrap).
- Assert `rst` low during WAIT of a store to 0x20 (prior value 0x11111111) -> state IDLE, a load of 0x20 returns 0x11111111.
- With `DMEM_ALIGN_CHECK_EN`: word store to 0x22 -> `err`=1 with `done` and memory unchanged. Without the macro, the same store writes word 0x20 and `err` stays 0.
